// File: rtl/counter_job_scheduler.sv
// Round-robin job scheduler for a shared load/up/down counter.
// Loads, steps and captures the counter, then checks the result.
module counter_job_scheduler #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 4,
  parameter int UP_INC = 3,
  parameter int DN_DEC = 5
) (
  input  logic              clk,
  input  logic              clearBar,
  input  logic              req_a,
  input  logic              dir_a,
  input  logic [WIDTH-1:0]  load_a,
  input  logic [STEP_W-1:0] steps_a,
  input  logic              req_b,
  input  logic              dir_b,
  input  logic [WIDTH-1:0]  load_b,
  input  logic [STEP_W-1:0] steps_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              busy,
  output logic              done,
  output logic              done_owner,
  output logic [WIDTH-1:0]  result,
  output logic              err,
  output logic              ctr_enable,
  output logic              ctr_up_downBar,
  output logic [WIDTH-1:0]  ctr_in,
  input  logic [WIDTH-1:0]  ctr_out
);

  typedef enum logic [1:0] {
    IDLE, LOAD, RUN, CAPTURE
  } state_t;

  localparam logic [WIDTH-1:0]  UP_V = WIDTH'(UP_INC);
  localparam logic [WIDTH-1:0]  DN_V = WIDTH'(DN_DEC);
  localparam logic [STEP_W-1:0] ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] ZERO = '0;

  state_t state, state_n;

  logic              last_owner;
  logic              owner;
  logic              dir_q;
  logic [WIDTH-1:0]  load_q;
  logic [STEP_W-1:0] steps_q;
  logic [STEP_W-1:0] remaining;
  logic [WIDTH-1:0]  expected;
  logic [WIDTH-1:0]  hold_val;

  logic grant;
  logic pick_b;

  // Arbitration: a tie goes to whoever did not win last time.
  always_comb begin
    grant  = req_a | req_b;
    pick_b = 1'b0;
    unique case (1'b1)
      (req_a & req_b):  pick_b = ~last_owner;
      (req_b & ~req_a): pick_b = 1'b1;
      default:          pick_b = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (grant) state_n = LOAD;
      LOAD:    state_n = (steps_q == ZERO) ? CAPTURE : RUN;
      RUN:     if (remaining == ONE) state_n = CAPTURE;
      CAPTURE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Counter has no hold mode, so idle reloads the held value.
  always_comb begin
    ctr_enable     = 1'b1;
    ctr_up_downBar = 1'b0;
    ctr_in         = hold_val;
    unique case (state)
      LOAD:    ctr_in = load_q;
      RUN: begin
        ctr_enable     = 1'b0;
        ctr_up_downBar = dir_q;
      end
      CAPTURE: ctr_in = ctr_out;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clearBar) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      dir_q      <= 1'b0;
      load_q     <= '0;
      steps_q    <= '0;
      remaining  <= '0;
      expected   <= '0;
      hold_val   <= '0;
      result     <= '0;
      done_owner <= 1'b0;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_n;
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            dir_q      <= pick_b ? dir_b   : dir_a;
            load_q     <= pick_b ? load_b  : load_a;
            steps_q    <= pick_b ? steps_b : steps_a;
            expected   <= pick_b ? load_b  : load_a;
            owner      <= pick_b;
            last_owner <= pick_b;
            gnt_a      <= ~pick_b;
            gnt_b      <= pick_b;
            busy       <= 1'b1;
          end
        end
        LOAD: remaining <= steps_q;
        RUN: begin
          remaining <= remaining - ONE;
          expected  <= dir_q ? expected + UP_V
                             : expected - DN_V;
        end
        CAPTURE: begin
          result     <= ctr_out;
          hold_val   <= ctr_out;
          done       <= 1'b1;
          err        <= (ctr_out != expected);
          done_owner <= owner;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/counter_job_scheduler.md
Name: counter_job_scheduler

Overview:
- Sequences and shares the 4-bit up/down counter (load / +3 / −5) between two requesters, A and B.
- Each requester submits a job: start value, direction and step count. The block arbitrates round-robin, loads the counter, steps it, captures the result and checks it against an internally computed expected value.
- The counter changes every clock and has no hold mode. The block therefore keeps the counter stable while idle by reloading the held value each cycle.

Parameters:
- WIDTH, 4, counter data width (all value arithmetic is modulo 2^WIDTH).
- STEP_W, 4, step-count width (max job length 2^STEP_W−1 steps).
- UP_INC, 3, counter increment per up step.
- DN_DEC, 5, counter decrement per down step.

Ports:
- clk  in  1  system clock, rising edge.
- clearBar  in  1  synchronous active-low reset, sampled on rising clk.
- req_a  in  1  requester A job request, held until gnt_a.
- dir_a  in  1  A direction, 1=up(+UP_INC), 0=down(−DN_DEC).
- load_a  in  WIDTH  A start value.
- steps_a  in  STEP_W  A step count.
- req_b, dir_b, load_b, steps_b  in  1/1/WIDTH/STEP_W  same fields for requester B.
- gnt_a, gnt_b  out  1  one-cycle grant pulse; payload was latched on the preceding edge.
- busy  out  1  high in LOAD, RUN and CAPTURE.
- done  out  1  one-cycle pulse; result valid.
- done_owner  out  1  0=A, 1=B; valid with done, held until next done.
- result  out  WIDTH  captured counter value, held until next done.
- err  out  1  pulses with done when the captured value ≠ expected.
- ctr_enable  out  1  counter load enable (1=load ctr_in).
- ctr_up_downBar  out  1  counter direction when ctr_enable=0.
- ctr_in  out  WIDTH  counter load data.
- ctr_out  in  WIDTH  counter registered output.

Behaviour:
- Reset (clearBar=0 at an edge):
  - State goes to IDLE.
  - gnt_a, gnt_b, busy, done, err and done_owner are all 0; result=0; hold_val=0; expected=0.
  - last_owner=B, so A wins the first tie.
  - Reset overrides everything, including mid-job. An aborted job produces no done and is dropped.
- FSM states: IDLE, LOAD, RUN, CAPTURE.
- IDLE:
  - Outputs: ctr_enable=1, ctr_in=hold_val, ctr_up_downBar=0.
  - If any request is pending at an edge, grant one of them:
    - only A pending → A;
    - only B pending → B;
    - both pending → the one ≠ last_owner.
  - On grant: latch dir, load and steps; set expected=load; set owner; set last_owner=owner; go to LOAD.
  - gnt_x is high for exactly the LOAD cycle.
- LOAD:
  - Outputs: ctr_enable=1, ctr_in=latched load.
  - remaining=steps.
  - Next state: CAPTURE if steps==0, else RUN.
- RUN:
  - Outputs: ctr_enable=0, ctr_up_downBar=dir.
  - Each edge: remaining−−; expected=expected+UP_INC or expected−DN_DEC, truncated to WIDTH.
  - Leave for CAPTURE on the edge where remaining==1, so RUN lasts exactly `steps` cycles.
- CAPTURE:
  - Outputs: ctr_enable=1, ctr_in=ctr_out (freezes the counter).
  - At the edge: result=ctr_out, hold_val=ctr_out, done=1, err=(ctr_out≠expected), done_owner=owner; go to IDLE.
- Latency: request sampled at edge T → gnt in cycle T+1 → done/result visible in cycle T+N+3, where N=steps.
- busy is registered and is high from cycle T+1 through cycle T+N+2.
- Requests that arrive while busy wait; they are not queued beyond the req level.
- A req still high after its grant is treated as a new job, which the block may grant back-to-back from the IDLE cycle following done.
- A req dropped before grant is ignored; no partial state is kept.
- Payload inputs are sampled only at the grant edge. Changes after grant have no effect.
- Wrap-around: all values wrap modulo 2^WIDTH with no saturation and no flag.
- Back-to-back fairness: if A and B both hold req continuously, grants alternate A, B, A, …

Test Plan:
- Reset, then A: load=2, dir=1, steps=4 → gnt_a 1 cycle; busy 6 cycles; done with result=14 (2+12), done_owner=0, err=0; ctr_in=14 while idle after.
- B alone: load=3, dir=0, steps=2 → result=9 (3−10 mod 16), done_owner=1, err=0.
- Wrap and zero-step:
  - A: load=14, dir=1, steps=1 → result=1.
  - Then A: load=7, steps=0 → RUN skipped; done 3 cycles after the request edge; result=7.
- Simultaneous requests held continuously after reset → grant order A, B, A, B; each done_owner matches; no back-to-back grant to the same side.
- Reset mid-job: A steps=10; drive clearBar=0 in the 4th RUN cycle → next cycle all outputs 0, state IDLE, ctr_enable=1, ctr_in=0, no done; a following B job completes normally.
- Fault check: counter model forced to add 2 instead of 3; A: load=0, up, steps=3 → result=6, err=1 with done.
